// File: rtl/fhe_ibutterfly.sv
// Gentleman-Sande inverse-NTT butterfly: a' = a+b mod p, b' = (a-b)*W*R^-1 mod p.
// Three pipelined multipliers (Montgomery reduction) feed a registered output FIFO.
module fhe_ibutterfly #(
    parameter int FSIZE       = 64,
    parameter int MULT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_valid,
    input  logic [FSIZE-1:0] cfg_p,
    input  logic [FSIZE-1:0] cfg_pinv,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FSIZE-1:0] in_a,
    input  logic [FSIZE-1:0] in_b,
    input  logic [FSIZE-1:0] in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FSIZE-1:0] out_a,
    output logic [FSIZE-1:0] out_b,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int ML = 3 * MULT_CYCLES;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);

    function automatic logic [FSIZE-1:0] mod_add(input logic [FSIZE-1:0] x,
                                                 input logic [FSIZE-1:0] y,
                                                 input logic [FSIZE-1:0] m);
        logic [FSIZE:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[FSIZE-1:0];
    endfunction

    // Wraparound in the second branch is harmless: the true result is below p.
    function automatic logic [FSIZE-1:0] mod_sub(input logic [FSIZE-1:0] x,
                                                 input logic [FSIZE-1:0] y,
                                                 input logic [FSIZE-1:0] m);
        return (x >= y) ? (x - y) : (x + m - y);
    endfunction

    function automatic logic [2*FSIZE-1:0] mul_wide(input logic [FSIZE-1:0] x,
                                                    input logic [FSIZE-1:0] y);
        return {{FSIZE{1'b0}}, x} * {{FSIZE{1'b0}}, y};
    endfunction

    function automatic logic [FSIZE-1:0] mul_hi(input logic [FSIZE-1:0] x,
                                                input logic [FSIZE-1:0] y);
        logic [2*FSIZE-1:0] prod;
        prod = mul_wide(x, y);
        return prod[2*FSIZE-1:FSIZE];
    endfunction

    logic [FSIZE-1:0]   p_q, pinv_q;
    logic [CW-1:0]      credits;
    logic               accept, pop, cfg_ok;

    logic [FSIZE-1:0]   sum_p0, d_p0, w_p0;
    logic               vld_p0;
    logic [2*FSIZE-1:0] u_pipe  [MULT_CYCLES];
    logic [FSIZE-1:0]   q_pipe  [MULT_CYCLES];
    logic [FSIZE-1:0]   h_pipe  [MULT_CYCLES];
    logic [FSIZE-1:0]   u1_dly  [2*MULT_CYCLES];
    logic [FSIZE-1:0]   sum_dly [ML];
    logic [ML-1:0]      vld_dly;
    logic [2*FSIZE-1:0] u_p1;
    logic [FSIZE-1:0]   q_p2, h_p3, u1_p3, sum_p3;
    logic               vld_p3;
    logic [FSIZE-1:0]   sum_p4, v_p4;
    logic               vld_p4;

    logic [2*FSIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;

    assign in_ready  = rstn && (credits != '0);
    assign busy      = (credits != FULL_CREDITS);
    assign accept    = in_valid && in_ready;
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign cfg_ok    = cfg_valid && !busy && !accept;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits <= FULL_CREDITS;
            p_q     <= '0;
            pinv_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && !cfg_ok;
            if (cfg_ok) begin
                p_q    <= cfg_p;
                pinv_q <= cfg_pinv;
            end
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // S0: modular sum / difference, twiddle latched
    always_ff @(posedge clk) begin
        if (accept) begin
            sum_p0 <= mod_add(in_a, in_b, p_q);
            d_p0   <= mod_sub(in_a, in_b, p_q);
            w_p0   <= in_w;
        end
    end

    // Mult1..Mult3 with the sum and U1 delay lines kept in step
    always_ff @(posedge clk) begin
        u_pipe[0]  <= mul_wide(d_p0, w_p0);
        q_pipe[0]  <= u_p1[FSIZE-1:0] * pinv_q;
        h_pipe[0]  <= mul_hi(q_p2, p_q);
        u1_dly[0]  <= u_p1[2*FSIZE-1:FSIZE];
        sum_dly[0] <= sum_p0;
        for (int i = 1; i < MULT_CYCLES; i++) begin
            u_pipe[i] <= u_pipe[i-1];
            q_pipe[i] <= q_pipe[i-1];
            h_pipe[i] <= h_pipe[i-1];
        end
        for (int i = 1; i < 2 * MULT_CYCLES; i++) u1_dly[i] <= u1_dly[i-1];
        for (int i = 1; i < ML; i++) sum_dly[i] <= sum_dly[i-1];
    end

    assign u_p1   = u_pipe[MULT_CYCLES-1];
    assign q_p2   = q_pipe[MULT_CYCLES-1];
    assign h_p3   = h_pipe[MULT_CYCLES-1];
    assign u1_p3  = u1_dly[2*MULT_CYCLES-1];
    assign sum_p3 = sum_dly[ML-1];
    assign vld_p3 = vld_dly[ML-1];

    // S4: final Montgomery correction; U1 - H lies in (-p, p)
    always_ff @(posedge clk) begin
        v_p4   <= mod_sub(u1_p3, h_p3, p_q);
        sum_p4 <= sum_p3;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p0  <= 1'b0;
            vld_dly <= '0;
            vld_p4  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            vld_p0  <= accept;
            vld_dly <= {vld_dly[ML-2:0], vld_p0};
            vld_p4  <= vld_p3;
            if (vld_p4) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO: space is guaranteed by the credit counter
    always_ff @(posedge clk) begin
        if (vld_p4) fifo_mem[wr_ptr[AW-1:0]] <= {sum_p4, v_p4};
    end

    assign {out_a, out_b} = fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_fhe_ibutterfly.sv
// Bench for fhe_ibutterfly: directed vectors, random streams, backpressure,
// config rejection and mid-flight reset against a plain modular-arithmetic model.
module tb_fhe_ibutterfly;

    localparam int FSIZE = 16;
    localparam int MC    = 3;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [FSIZE-1:0] cfg_p = '0, cfg_pinv = '0;
    logic             cfg_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [FSIZE-1:0] in_a = '0, in_b = '0, in_w = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [FSIZE-1:0] out_a, out_b;
    logic             busy;

    fhe_ibutterfly #(.FSIZE(FSIZE), .MULT_CYCLES(MC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_p(cfg_p), .cfg_pinv(cfg_pinv), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a, b, w, p, rinv;
    } txn_t;

    txn_t        acc_q[$];
    logic [31:0] got_q[$];
    txn_t        mon_t;
    logic [15:0] cur_p = '0, cur_rinv = '0;
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready) begin
                mon_t.a = in_a; mon_t.b = in_b; mon_t.w = in_w;
                mon_t.p = cur_p; mon_t.rinv = cur_rinv;
                acc_q.push_back(mon_t);
            end
            if (out_valid && out_ready) got_q.push_back({out_a, out_b});
        end
    end

    // out_b * R == (a-b) * W (mod p), so multiply by R^-1 mod p
    function automatic logic [31:0] model(input txn_t t);
        longint p, s, d, r;
        p = longint'(t.p);
        s = (longint'(t.a) + longint'(t.b)) % p;
        d = (longint'(t.a) - longint'(t.b) + p) % p;
        r = (((d * longint'(t.w)) % p) * longint'(t.rinv)) % p;
        return {s[15:0], r[15:0]};
    endfunction

    function automatic logic [15:0] rinv_of(input logic [15:0] p);
        for (int x = 0; x < int'(p); x++)
            if ((longint'(x) * 65536) % longint'(p) == 1) return 16'(x);
        return 16'd0;
    endfunction

    function automatic logic [15:0] pinv_of(input logic [15:0] p);
        logic [15:0] x;
        x = p;
        repeat (5) x = x * (16'd2 - p * x);
        return x;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] w);
        in_valid = 1'b1; in_a = a; in_b = b; in_w = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        rstn = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_cfg_idle();
        bit ok;
        cfg_valid = 1'b1; cfg_p = 16'd7681; cfg_pinv = pinv_of(16'd7681);
        tick();
        cfg_valid = 1'b0;
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_idle_err got=%b exp=0", cfg_err); end
        cur_p = 16'd7681; cur_rinv = rinv_of(16'd7681);
        acc_q.delete(); got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send(16'($urandom_range(7680, 0)), 16'($urandom_range(7680, 0)), 16'($urandom_range(7680, 0)));
        wait_idle(100, ok);
        n_tests++; if (!ok || got_q.size() != 4) begin n_fail++; $display("FAIL cfg_idle_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== model(acc_q[i])) begin
                n_fail++; $display("FAIL cfg_idle_data[%0d] got=%h exp=%h", i, got_q[i], model(acc_q[i]));
            end
        end
        cfg_valid = 1'b1; cfg_p = 16'd12289; cfg_pinv = 16'hD001;
        tick();
        cfg_valid = 1'b0;
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_main_err got=%b exp=0", cfg_err); end
        cur_p = 16'd12289; cur_rinv = rinv_of(16'd12289);
    endtask

    task automatic test_directed();
        logic [15:0] va[4] = '{16'd5, 16'd3, 16'd12288, 16'd100};
        logic [15:0] vb[4] = '{16'd3, 16'd5, 16'd12288, 16'd7};
        logic [15:0] vw[4] = '{16'd4091, 16'd4091, 16'd4091, 16'd0};
        logic [15:0] ea[4] = '{16'd8, 16'd8, 16'd12287, 16'd107};
        logic [15:0] eb[4] = '{16'd2, 16'd12287, 16'd0, 16'd0};
        bit ok, seen;
        int t_acc;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            acc_q.delete(); got_q.delete();
            send(va[v], vb[v], vw[v]);
            t_acc = cyc - 1;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (out_valid) begin seen = 1'b1; break; end
                tick();
            end
            n_tests++;
            if (!seen || (cyc - t_acc) != 12) begin
                n_fail++; $display("FAIL latency[%0d] got=%0d seen=%b exp=12", v, cyc - t_acc, seen);
            end
            wait_idle(20, ok);
            n_tests++;
            if (!ok || got_q.size() != 1) begin
                n_fail++; $display("FAIL directed_count[%0d] got=%0d exp=1", v, got_q.size());
            end else if (got_q[0] !== {ea[v], eb[v]}) begin
                n_fail++; $display("FAIL directed[%0d] got a=%0d b=%0d exp a=%0d b=%0d",
                                   v, got_q[0][31:16], got_q[0][15:0], ea[v], eb[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int stalls = 0;
        acc_q.delete(); got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom_range(12288, 0));
            in_b = 16'($urandom_range(12288, 0));
            in_w = 16'($urandom_range(12288, 0));
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
        wait_idle(100, ok);
        n_tests++; if (!ok || got_q.size() != 32) begin n_fail++; $display("FAIL b2b_count got=%0d exp=32", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== model(acc_q[i])) begin
                n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], model(acc_q[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        acc_q.delete(); got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom_range(12288, 0));
            in_b = 16'($urandom_range(12288, 0));
            in_w = 16'($urandom_range(12288, 0));
            tick();
        end
        n_tests++; if (acc_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=%0d", acc_q.size(), DEPTH); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(100, ok);
        n_tests++; if (!ok || got_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_pops got=%0d exp=%0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== model(acc_q[i])) begin
                n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_q[i], model(acc_q[i]));
            end
        end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_cfg_busy();
        bit ok;
        acc_q.delete(); got_q.delete();
        out_ready = 1'b1;
        send(16'd12000, 16'd12000, 16'd4091);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfgb_busy got=%b exp=1", busy); end
        cfg_valid = 1'b1; cfg_p = 16'd7681; cfg_pinv = pinv_of(16'd7681);
        tick();
        cfg_valid = 1'b0;
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfgb_err_pulse got=%b exp=1", cfg_err); end
        tick();
        n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfgb_err_width got=%b exp=0", cfg_err); end
        wait_idle(40, ok);
        // idle, but an accept in the same cycle must still block the write
        in_valid = 1'b1; in_a = 16'd12288; in_b = 16'd1; in_w = 16'd4091;
        cfg_valid = 1'b1;
        tick();
        in_valid = 1'b0; cfg_valid = 1'b0;
        n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_accept_err got=%b exp=1", cfg_err); end
        wait_idle(40, ok);
        n_tests++; if (!ok || got_q.size() != 2) begin n_fail++; $display("FAIL cfgb_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_tests++; if (got_q[0] !== {16'd11711, 16'd0}) begin n_fail++; $display("FAIL cfgb_old_p0 got=%h exp=%h", got_q[0], {16'd11711, 16'd0}); end
            n_tests++; if (got_q[1] !== {16'd0, 16'd12287}) begin n_fail++; $display("FAIL cfgb_old_p1 got=%h exp=%h", got_q[1], {16'd0, 16'd12287}); end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(i + 1), 16'd2, 16'd4091);
        repeat (14) tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered got=%b exp=1", out_valid); end
        for (int i = 0; i < 5; i++) send(16'(i + 10), 16'd3, 16'd4091);
        rstn = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        rstn = 1'b1;
        out_ready = 1'b1;
        acc_q.delete(); got_q.delete();
        repeat (25) tick();
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_stale got=%0d exp=0", got_q.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        test_reset();
        test_cfg_idle();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_cfg_busy();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fhe_ibutterfly.md
Name: fhe_ibutterfly

Overview:
- Gentleman-Sande inverse-NTT butterfly, the decode-direction counterpart of the forward Cooley-Tukey butterfly ALU.
- Per transaction (a, b, W): a_out = (a + b) mod p, b_out = (a − b)·W·R⁻¹ mod p, with R = 2^FSIZE and W supplied in Montgomery form.
- Fully pipelined, one transaction per cycle, valid/ready on both sides, internal output FIFO with credit-based input throttling.
- Sits between the INTT coefficient streamer and the writeback path.

Parameters:
FSIZE, 64, operand width; R = 2^FSIZE.
MULT_CYCLES, 4, latency of each Mult instance (≥1).
FIFO_DEPTH, 16, output FIFO entries; power of two, ≥2.

Ports:
clk  in  1  clock.
rstn  in  1  reset.
cfg_valid  in  1  load modulus pair this cycle.
cfg_p  in  FSIZE  modulus p: odd, p < 2^(FSIZE-1).
cfg_pinv  in  FSIZE  p⁻¹ mod R (positive inverse).
cfg_err  out  1  one-cycle pulse: cfg write rejected.
in_valid  in  1  input transaction offered.
in_ready  out  1  input accepted when in_valid & in_ready.
in_a  in  FSIZE  operand a, < p.
in_b  in  FSIZE  operand b, < p.
in_w  in  FSIZE  twiddle, Montgomery form, < p.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_a  out  FSIZE  (a+b) mod p.
out_b  out  FSIZE  (a−b)·W·R⁻¹ mod p.
busy  out  1  any transaction in pipeline or FIFO.

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk.
- Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0; busy=0; cfg_err=0; p=pinv=0; pipeline valid bits cleared; FIFO empty; credits=FIFO_DEPTH. Data registers need no reset.
- Reset mid-operation discards all in-flight and buffered transactions.
- S0, registered on accept:
  - s = a + b computed in FSIZE+1 bits; sum = s ≥ p ? s − p : s.
  - d = a ≥ b ? a − b : a + p − b.
  - W is latched alongside.
- Mult1: U = d·W (2·FSIZE bits).
- Mult2: Q = U[FSIZE-1:0]·pinv, low FSIZE bits kept.
- Mult3: H = (Q·p)[2·FSIZE-1:FSIZE].
  - U1 = U[2·FSIZE-1:FSIZE] is carried in a delay line of 2·MULT_CYCLES.
- S4, registered: V = U1 ≥ H ? U1 − H : U1 + p − H.
- sum is carried in a delay line matching the multiplier path; sum and V are written into the FIFO together.
- Latency: accept at cycle t → FIFO write at t + 3·MULT_CYCLES + 2. out_valid rises the following cycle if the FIFO was empty (FIFO registered, no bypass).
- Credits: credits = FIFO_DEPTH − (in-flight + FIFO count).
  - Decrement on accept; increment on FIFO pop (out_valid & out_ready).
  - Same-cycle accept and pop leaves credits unchanged.
  - in_ready = (credits ≠ 0). The FIFO therefore never overflows, and out_ready=0 indefinitely stalls input after exactly FIFO_DEPTH accepts.
- Ordering: strictly in order; throughput 1/cycle when out_ready is held 1.
- busy = (credits ≠ FIFO_DEPTH).
- cfg write:
  - Applied at the clock edge only when busy=0 and no accept occurs in the same cycle.
  - Otherwise ignored, and cfg_err pulses for 1 cycle.
  - p/pinv are static while any transaction is outstanding.
- FIFO: pointer wrap at FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
  - Pop on empty is impossible (out_valid=0). Push on full is impossible (credits).
- out_a/out_b hold their value while out_valid & !out_ready.
- Inputs ≥ p, or even p: results undefined; no check required.

Test Plan:
- FSIZE=16, MULT_CYCLES=3, FIFO_DEPTH=16; cfg p=12289, pinv=0xD001; W=4091 (R mod p):
  - a=5, b=3 → out_a=8, out_b=2; out_valid rises 12 cycles after accept.
  - a=3, b=5 → out_a=8, out_b=12287. a=12288, b=12288 → out_a=12287, out_b=0.
- W=0, a=100, b=7 → out_a=107, out_b=0. Back-to-back stream of 32 random (a,b,W) with out_ready=1 → in_ready stays 1, results match the golden model in order.
- out_ready=0, in_valid=1 continuous → exactly 16 accepts, then in_ready=0. Release out_ready → 16 pops in order, then in_ready returns 1.
- cfg_valid while busy=1 → cfg_err pulses 1 cycle; later results still use the old p.
- cfg_valid when idle → accepted, no cfg_err.
- Assert rstn=0 with 5 in flight and 3 buffered → out_valid=0, busy=0 next cycle; no stale outputs afterward.
